// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: opcode encodings, instruction
// field layout, sequencer states and small decode helpers.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned EXT_W   = 64;

  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] ADD_OP = 4'd0;
  localparam logic [OPC_W-1:0] SUB_OP = 4'd1;
  localparam logic [OPC_W-1:0] MUL_OP = 4'd2;
  localparam logic [OPC_W-1:0] DIV_OP = 4'd3;
  localparam logic [OPC_W-1:0] AND_OP = 4'd4;
  localparam logic [OPC_W-1:0] OR_OP  = 4'd5;
  localparam logic [OPC_W-1:0] XOR_OP = 4'd6;
  localparam logic [OPC_W-1:0] LW_OP  = 4'd7;
  localparam logic [OPC_W-1:0] SW_OP  = 4'd8;
  localparam logic [OPC_W-1:0] LI_OP  = 4'd9;
  localparam logic [OPC_W-1:0] JMP_OP = 4'd10;
  localparam logic [OPC_W-1:0] BEQ_OP = 4'd11;
  localparam logic [OPC_W-1:0] BGT_OP = 4'd12;
  localparam logic [OPC_W-1:0] BLT_OP = 4'd13;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Wide sign extension; callers truncate to their datapath width.
  function automatic logic [EXT_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(EXT_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic is_branch_op(input logic [OPC_W-1:0] op);
    return (op == JMP_OP) || (op == BEQ_OP) || (op == BGT_OP) || (op == BLT_OP);
  endfunction

  function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
    return (op == LW_OP) || (op == SW_OP);
  endfunction

  function automatic logic is_rr_op(input logic [OPC_W-1:0] op);
    return op <= XOR_OP;
  endfunction

  function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
    return op > BLT_OP;
  endfunction

endpackage

// File: rtl/branch_unit.sv
// Branch resolution: signed compare of the latched rs1/rs2 values under the
// current opcode; JMP is unconditionally taken.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [OPC_W-1:0]     opcode,
  input  logic [DATAWIDTH-1:0] rs1,
  input  logic [DATAWIDTH-1:0] rs2,
  output logic                 taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (opcode)
      JMP_OP:  taken_c = 1'b1;
      BEQ_OP:  taken_c = (rs1 == rs2);
      BGT_OP:  taken_c = ($signed(rs1) > $signed(rs2));
      BLT_OP:  taken_c = ($signed(rs1) < $signed(rs2));
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer: fetch, decode, ALU issue, data-memory
// handshake, write-back and PC update. All outputs are registered.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned         DATAWIDTH = 32,
  parameter int unsigned         PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_o,
  output logic [PC_WIDTH-1:0]  imem_addr_o,
  input  logic                 imem_ack_i,
  input  logic [INSTR_W-1:0]   imem_data_i,
  output logic [REG_W-1:0]     rf_raddr1_o,
  output logic [REG_W-1:0]     rf_raddr2_o,
  input  logic [DATAWIDTH-1:0] rf_rdata1_i,
  input  logic [DATAWIDTH-1:0] rf_rdata2_i,
  output logic [DATAWIDTH-1:0] alu_a_o,
  output logic [DATAWIDTH-1:0] alu_b_o,
  output logic [OPC_W-1:0]     alu_opcode_o,
  input  logic [DATAWIDTH-1:0] alu_out_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [PC_WIDTH-1:0]  dmem_addr_o,
  output logic [DATAWIDTH-1:0] dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [DATAWIDTH-1:0] dmem_rdata_i,
  output logic                 rf_we_o,
  output logic [REG_W-1:0]     rf_waddr_o,
  output logic [DATAWIDTH-1:0] rf_wdata_o,
  output logic                 illegal_o
);

  state_t               state;
  logic [PC_WIDTH-1:0]  pc;
  logic [OPC_W-1:0]     op;
  logic [REG_W-1:0]     rd;
  logic [IMM_W-1:0]     imm;
  logic [DATAWIDTH-1:0] rs1_val;
  logic [DATAWIDTH-1:0] rs2_val;

  logic                 taken_c;
  logic [DATAWIDTH-1:0] imm_ext_c;
  logic [PC_WIDTH-1:0]  pc_inc_c;
  logic [PC_WIDTH-1:0]  pc_br_c;

  assign imm_ext_c = DATAWIDTH'(sext_imm(imm));
  assign pc_inc_c  = pc + PC_WIDTH'(1);
  assign pc_br_c   = taken_c ? alu_out_i[PC_WIDTH-1:0] : pc_inc_c;

  branch_unit #(.DATAWIDTH(DATAWIDTH)) u_branch (
    .opcode  (op),
    .rs1     (rs1_val),
    .rs2     (rs2_val),
    .taken_c (taken_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      op           <= '0;
      rd           <= '0;
      imm          <= '0;
      rs1_val      <= '0;
      rs2_val      <= '0;
      imem_req_o   <= 1'b0;
      imem_addr_o  <= '0;
      rf_raddr1_o  <= '0;
      rf_raddr2_o  <= '0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_opcode_o <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      illegal_o    <= 1'b0;
    end else begin
      rf_we_o <= 1'b0;
      case (state)
        // Out of reset the request is raised here; afterwards it arrives pre-set.
        S_FETCH: begin
          if (!imem_req_o) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
          end else if (imem_ack_i) begin
            imem_req_o  <= 1'b0;
            op          <= imem_data_i[OPC_LSB +: OPC_W];
            rd          <= imem_data_i[RD_LSB +: REG_W];
            imm         <= imem_data_i[IMM_LSB +: IMM_W];
            rf_raddr1_o <= imem_data_i[RS1_LSB +: REG_W];
            rf_raddr2_o <= imem_data_i[RS2_LSB +: REG_W];
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          rs1_val      <= rf_rdata1_i;
          rs2_val      <= rf_rdata2_i;
          alu_opcode_o <= op;
          if (is_rr_op(op)) begin
            alu_a_o <= rf_rdata1_i;
            alu_b_o <= rf_rdata2_i;
          end else if (op == LI_OP) begin
            alu_a_o <= '0;
            alu_b_o <= imm_ext_c;
          end else if (is_branch_op(op)) begin
            alu_a_o <= DATAWIDTH'(pc);
            alu_b_o <= imm_ext_c;
          end else begin
            alu_a_o <= rf_rdata1_i;
            alu_b_o <= imm_ext_c;
          end
          if (is_illegal_op(op)) begin
            illegal_o <= 1'b1;
            state     <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_branch_op(op)) begin
            pc          <= pc_br_c;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_br_c;
            state       <= S_FETCH;
          end else if (is_mem_op(op)) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= (op == SW_OP);
            dmem_addr_o  <= alu_out_i[PC_WIDTH-1:0];
            dmem_wdata_o <= rs2_val;
            state        <= S_MEM;
          end else begin
            rf_we_o    <= (rd != '0);
            rf_waddr_o <= rd;
            rf_wdata_o <= alu_out_i;
            state      <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              pc          <= pc_inc_c;
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc_inc_c;
              state       <= S_FETCH;
            end else begin
              rf_we_o    <= (rd != '0);
              rf_waddr_o <= rd;
              rf_wdata_o <= dmem_rdata_i;
              state      <= S_WB;
            end
          end
        end
        S_WB: begin
          pc          <= pc_inc_c;
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc_inc_c;
          state       <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: acts as imem, register file, ALU and dmem,
// and compares against an instruction-level reference model.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req_o;
  logic [PW-1:0] imem_addr_o;
  logic          imem_ack_i = 1'b0;
  logic [31:0]   imem_data_i = '0;
  logic [3:0]    rf_raddr1_o, rf_raddr2_o;
  logic [DW-1:0] rf_rdata1_i, rf_rdata2_i;
  logic [DW-1:0] alu_a_o, alu_b_o;
  logic [3:0]    alu_opcode_o;
  logic [DW-1:0] alu_out_i;
  logic          dmem_req_o, dmem_we_o;
  logic [PW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic          dmem_ack_i = 1'b0;
  logic [DW-1:0] dmem_rdata_i = '0;
  logic          rf_we_o;
  logic [3:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          illegal_o;

  logic [DW-1:0] regs [16];
  logic [PW-1:0] mpc;
  int checks = 0;
  int errors = 0;

  cpu_ctrl #(.DATAWIDTH(DW), .PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
    .alu_out_i(alu_out_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // Environment: combinational register file and ALU.
  assign rf_rdata1_i = regs[rf_raddr1_o];
  assign rf_rdata2_i = regs[rf_raddr2_o];

  function automatic logic [DW-1:0] alu_env(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      ADD_OP:  return a + b;
      SUB_OP:  return a - b;
      MUL_OP:  return a * b;
      DIV_OP:  return (b == '0) ? '1 : a / b;
      AND_OP:  return a & b;
      OR_OP:   return a | b;
      XOR_OP:  return a ^ b;
      LI_OP:   return b;
      default: return a + b;
    endcase
  endfunction

  always_comb alu_out_i = alu_env(alu_opcode_o, alu_a_o, alu_b_o);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_strobes", 64'({imem_req_o, dmem_req_o, rf_we_o, illegal_o, dmem_we_o}), 64'd0);
    check_eq("rst_addr", 64'({imem_addr_o, dmem_addr_o}), 64'd0);
    check_eq("rst_data", 64'({alu_a_o, rf_wdata_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_fetch", 64'({imem_req_o, imem_addr_o}), 64'({1'b1, 16'd0}));
    mpc = '0;
  endtask

  // Runs one legal instruction from its fetch cycle to the next fetch cycle.
  task automatic exec_instr(input logic [31:0] ins, input int iw, input int dw, input logic [DW-1:0] ld);
    logic [3:0]    op, rd;
    logic [DW-1:0] r1, r2, immx, ea, eb, wd;
    logic          ewe, emem, taken;
    logic [PW-1:0] npc, daddr;
    int            lat, cyc, we_cnt, dreq_cnt;
    logic [3:0]    got_wa;
    logic [DW-1:0] got_wd;
    logic          done;

    op   = ins[31:28];
    rd   = ins[27:24];
    r1   = regs[ins[23:20]];
    r2   = regs[ins[19:16]];
    immx = {{16{ins[15]}}, ins[15:0]};
    ewe  = 1'b0; emem = 1'b0; wd = '0; taken = 1'b0;
    npc  = mpc + 16'd1;
    daddr = 16'(r1 + immx);
    ea = r1; eb = r2;
    lat = 4;
    case (op)
      ADD_OP: wd = r1 + r2;
      SUB_OP: wd = r1 - r2;
      MUL_OP: wd = r1 * r2;
      DIV_OP: wd = (r2 == 0) ? 32'hFFFF_FFFF : r1 / r2;
      AND_OP: wd = r1 & r2;
      OR_OP:  wd = r1 | r2;
      XOR_OP: wd = r1 ^ r2;
      LI_OP:  begin wd = immx; ea = '0; eb = immx; end
      LW_OP:  begin wd = ld; emem = 1'b1; eb = immx; lat = 5 + dw; end
      SW_OP:  begin emem = 1'b1; eb = immx; lat = 4 + dw; end
      default: begin
        ea = {16'd0, mpc}; eb = immx; lat = 3;
        taken = (op == JMP_OP) || (op == BEQ_OP && r1 == r2) ||
                (op == BGT_OP && $signed(r1) > $signed(r2)) ||
                (op == BLT_OP && $signed(r1) < $signed(r2));
        if (taken) npc = mpc + ins[15:0];
      end
    endcase
    if (op <= XOR_OP || op == LI_OP || op == LW_OP) ewe = (rd != 4'd0);
    lat = lat + iw;

    check_eq("fetch_req", 64'(imem_req_o), 64'd1);
    check_eq("fetch_addr", 64'(imem_addr_o), 64'(mpc));
    cyc = 1;
    for (int i = 0; i < iw; i++) begin
      imem_ack_i = 1'b0;
      imem_data_i = $urandom;
      @(negedge clk);
      cyc++;
    end
    if (iw > 0) check_eq("fetch_hold", 64'({imem_req_o, imem_addr_o}), 64'({1'b1, mpc}));
    imem_ack_i = 1'b1;
    imem_data_i = ins;
    dmem_ack_i = 1'($urandom % 2);
    @(negedge clk);
    cyc++;

    we_cnt = 0; dreq_cnt = 0; done = 1'b0; got_wa = '0; got_wd = '0;
    while (!done && cyc < 60) begin
      if (cyc == iw + 3) begin
        check_eq("alu_opcode", 64'(alu_opcode_o), 64'(op));
        check_eq("alu_a", 64'(alu_a_o), 64'(ea));
        check_eq("alu_b", 64'(alu_b_o), 64'(eb));
      end
      if (rf_we_o) begin
        we_cnt++;
        got_wa = rf_waddr_o;
        got_wd = rf_wdata_o;
      end
      if (dmem_req_o) begin
        dreq_cnt++;
        if (dreq_cnt == 1 || dreq_cnt == dw + 1)
          check_eq("dmem_req", 64'({dmem_we_o, dmem_addr_o, dmem_wdata_o}),
                   64'({op == SW_OP, daddr, r2}));
      end
      if (imem_req_o) done = 1'b1;
      else begin
        imem_ack_i = 1'($urandom % 2);
        imem_data_i = $urandom;
        dmem_ack_i = dmem_req_o ? (dreq_cnt == dw + 1) : 1'($urandom % 2);
        dmem_rdata_i = (dmem_req_o && dreq_cnt == dw + 1) ? ld : DW'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("latency", 64'(cyc - 1), 64'(lat));
    check_eq("dmem_cycles", 64'(dreq_cnt), emem ? 64'(dw + 1) : 64'd0);
    check_eq("rf_we_count", 64'(we_cnt), ewe ? 64'd1 : 64'd0);
    if (ewe) check_eq("rf_write", 64'({got_wa, got_wd}), 64'({rd, wd}));
    check_eq("next_pc", 64'(imem_addr_o), 64'(npc));
    if (ewe) regs[rd] = wd;
    mpc = npc;
  endtask

  task automatic run_illegal(input logic [3:0] op);
    int reqs;
    reqs = 0;
    check_eq("ill_fetch", 64'({imem_req_o, imem_addr_o}), 64'({1'b1, mpc}));
    imem_ack_i = 1'b1;
    imem_data_i = mk(op, 4'd1, 4'd2, 4'd3, 16'($urandom));
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      imem_ack_i = 1'($urandom % 2);
      dmem_ack_i = 1'($urandom % 2);
      @(negedge clk);
      if (imem_req_o || dmem_req_o || rf_we_o) reqs++;
    end
    check_eq("halt_quiet", 64'(reqs), 64'd0);
    check_eq("illegal", 64'(illegal_o), 64'd1);
    do_reset();
  endtask

  // Reset lands while a load waits for its ack: nothing may be written back.
  task automatic reset_mid_mem();
    int n;
    int wes;
    wes = 0;
    check_eq("mid_fetch", 64'(imem_req_o), 64'd1);
    imem_ack_i = 1'b1;
    imem_data_i = mk(LW_OP, 4'd7, 4'd1, 4'd2, 16'd3);
    dmem_ack_i = 1'b0;
    @(negedge clk);
    imem_ack_i = 1'b0;
    n = 0;
    while (!dmem_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_dreq", 64'(dmem_req_o), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_drop", 64'({dmem_req_o, rf_we_o, imem_req_o}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rf_we_o) wes++;
    end
    check_eq("mid_rst_no_wb", 64'(wes), 64'd0);
    check_eq("mid_rst_fetch", 64'({imem_req_o, imem_addr_o}), 64'({1'b1, 16'd0}));
    mpc = '0;
  endtask

  initial begin
    logic [3:0] rop;
    regs[0] = '0;
    for (int i = 1; i < 16; i++) regs[i] = DW'($urandom);
    regs[1] = 32'd34;
    regs[2] = 32'd35;
    do_reset();

    exec_instr(mk(ADD_OP, 4'd3, 4'd1, 4'd2, 16'd0), 0, 0, '0);
    check_eq("add_result", 64'(regs[3]), 64'd69);
    check_eq("add_next", 64'(imem_addr_o), 64'd1);

    exec_instr(mk(LI_OP, 4'd4, 4'd0, 4'd0, 16'hFFFE), 1, 0, '0);
    exec_instr(mk(SW_OP, 4'd0, 4'd0, 4'd4, 16'd8), 0, 3, '0);

    exec_instr(mk(JMP_OP, 4'd0, 4'd0, 4'd0, 16'(10 - 3)), 0, 0, '0);
    check_eq("jmp_target", 64'(imem_addr_o), 64'd10);
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'd1;
    exec_instr(mk(BLT_OP, 4'd0, 4'd1, 4'd2, 16'hFFFE), 0, 0, '0);
    check_eq("blt_taken", 64'(imem_addr_o), 64'd8);
    exec_instr(mk(JMP_OP, 4'd0, 4'd0, 4'd0, 16'd2), 0, 0, '0);
    regs[1] = 32'd2;
    exec_instr(mk(BLT_OP, 4'd0, 4'd1, 4'd2, 16'hFFFE), 0, 0, '0);
    check_eq("blt_not_taken", 64'(imem_addr_o), 64'd11);
    regs[5] = 32'h8000_0001;
    regs[6] = 32'h8000_0001;
    exec_instr(mk(BEQ_OP, 4'd0, 4'd5, 4'd6, 16'd4), 0, 0, '0);
    check_eq("beq_taken", 64'(imem_addr_o), 64'd15);

    exec_instr(mk(LW_OP, 4'd0, 4'd1, 4'd2, 16'd5), 0, 2, 32'hDEAD_BEEF);
    exec_instr(mk(DIV_OP, 4'd9, 4'd1, 4'd0, 16'd0), 0, 0, '0);

    for (int k = 0; k < 300; k++) begin
      rop = 4'($urandom_range(0, 13));
      exec_instr(mk(rop, 4'($urandom), 4'($urandom), 4'($urandom),
                    (k % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), DW'($urandom));
    end

    reset_mid_mem();
    exec_instr(mk(ADD_OP, 4'd8, 4'd1, 4'd2, 16'd0), 0, 0, '0);
    run_illegal(4'd15);
    run_illegal(4'd14);
    exec_instr(mk(LI_OP, 4'd2, 4'd0, 4'd0, 16'h7FFF), 2, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
